pong_collision_detector: RTL and testbench

- Game controller stage that sits directly upstream of the ball component and drives its bounce_trigger/bounce_direction inputs.
- Watches the VGA pixel scan (row, col, ball and paddle rgb) and detects wall contacts, paddle contacts and misses once per frame.
- Converts each detected event into a single bounce command held long enough for the ball to sample it exactly once, and keeps both players' scores.

---
 rtl/pong_collision_detector.sv | 156 +++++++++++++++
 tb/tb_pong_collision_detector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_collision_detector.sv
// Watches the VGA pixel scan for ball/wall/paddle contacts and misses.
// Converts each frame's events into one held bounce command and tracks both scores.
module pong_collision_detector #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned HOLD_CYCLES     = 10,
    parameter int unsigned COOLDOWN_FRAMES = 2,
    parameter int unsigned SCORE_MAX       = 9,
    parameter bit          SERVE_DIRECTION = 1'b1
) (
    input  logic       i_tick,
    input  logic       i_reset,
    input  logic [9:0] i_row,
    input  logic [9:0] i_col,
    input  logic [2:0] i_ball_rgb,
    input  logic [2:0] i_paddle_rgb,
    input  logic       i_frame_end,
    input  logic       i_serve,
    output logic       o_bounce_trigger,
    output logic       o_bounce_direction,
    output logic       o_miss,
    output logic [3:0] o_score_left,
    output logic [3:0] o_score_right
);

    localparam int unsigned COOL_W    = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [9:0]  ROW_END   = 10'(V_ACTIVE);
    localparam logic [9:0]  COL_END   = 10'(H_ACTIVE);
    localparam logic [9:0]  ROW_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  COL_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [3:0]  SCORE_SAT = 4'(SCORE_MAX);

    typedef enum logic {StScan, StHold} state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_hold, w_hold_next;
    logic [COOL_W-1:0] r_cool, w_cool_next;
    logic              r_wall_f, r_paddle_f, r_missl_f, r_missr_f;
    logic              w_wall_f_next, w_paddle_f_next, w_missl_f_next, w_missr_f_next;
    logic              r_trig, w_trig_next;
    logic              r_dir, w_dir_next;
    logic              r_miss, w_miss_next;
    logic [3:0]        r_score_l, w_score_l_next;
    logic [3:0]        r_score_r, w_score_r_next;

    logic w_ball_px;
    logic w_any_miss;
    logic w_fe_bounce;
    logic w_serve_ok;

    assign w_ball_px  = (i_row < ROW_END) && (i_col < COL_END) && (i_ball_rgb != 3'b000);
    assign w_any_miss = r_missl_f || r_missr_f;
    assign w_fe_bounce = i_frame_end && !w_any_miss && (r_cool == '0) && (r_state == StScan)
                         && (r_paddle_f || r_wall_f);
    // A frame_end bounce in the same cycle takes precedence over a serve.
    assign w_serve_ok = i_serve && (r_state == StScan) && (r_cool == '0) && !w_fe_bounce;

    always_ff @(posedge i_tick or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StScan;
            r_hold     <= '0;
            r_cool     <= '0;
            r_wall_f   <= 1'b0;
            r_paddle_f <= 1'b0;
            r_missl_f  <= 1'b0;
            r_missr_f  <= 1'b0;
            r_trig     <= 1'b0;
            r_dir      <= 1'b0;
            r_miss     <= 1'b0;
            r_score_l  <= '0;
            r_score_r  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold     <= w_hold_next;
            r_cool     <= w_cool_next;
            r_wall_f   <= w_wall_f_next;
            r_paddle_f <= w_paddle_f_next;
            r_missl_f  <= w_missl_f_next;
            r_missr_f  <= w_missr_f_next;
            r_trig     <= w_trig_next;
            r_dir      <= w_dir_next;
            r_miss     <= w_miss_next;
            r_score_l  <= w_score_l_next;
            r_score_r  <= w_score_r_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_hold_next     = r_hold;
        w_cool_next     = r_cool;
        w_trig_next     = r_trig;
        w_dir_next      = r_dir;
        w_miss_next     = 1'b0;
        w_score_l_next  = r_score_l;
        w_score_r_next  = r_score_r;
        w_wall_f_next   = r_wall_f;
        w_paddle_f_next = r_paddle_f;
        w_missl_f_next  = r_missl_f;
        w_missr_f_next  = r_missr_f;

        if (i_frame_end) begin
            w_wall_f_next   = 1'b0;
            w_paddle_f_next = 1'b0;
            w_missl_f_next  = 1'b0;
            w_missr_f_next  = 1'b0;
            if (r_cool != '0) begin
                w_cool_next = r_cool - 1'b1;
            end
            if (w_any_miss) begin
                w_miss_next = 1'b1;
                w_cool_next = '0;
                if (r_missl_f && (r_score_r < SCORE_SAT)) begin
                    w_score_r_next = r_score_r + 4'd1;
                end
                if (r_missr_f && (r_score_l < SCORE_SAT)) begin
                    w_score_l_next = r_score_l + 4'd1;
                end
            end
        end else if (w_ball_px) begin
            if ((i_row == 10'd0) || (i_row == ROW_LAST)) w_wall_f_next = 1'b1;
            if (i_paddle_rgb != 3'b000) w_paddle_f_next = 1'b1;
            if (i_col == 10'd0) w_missl_f_next = 1'b1;
            if (i_col == COL_LAST) w_missr_f_next = 1'b1;
        end

        unique case (r_state)
            StHold: begin
                if (r_hold == '0) begin
                    w_trig_next  = 1'b0;
                    w_state_next = StScan;
                end else begin
                    w_hold_next = r_hold - 8'd1;
                end
            end
            default: begin
                if (w_fe_bounce || w_serve_ok) begin
                    w_trig_next  = 1'b1;
                    w_dir_next   = w_fe_bounce ? r_paddle_f : SERVE_DIRECTION;
                    w_state_next = StHold;
                    w_hold_next  = HOLD_LOAD;
                    w_cool_next  = COOL_LOAD;
                end
            end
        endcase
    end

    assign o_bounce_trigger   = r_trig;
    assign o_bounce_direction = r_dir;
    assign o_miss             = r_miss;
    assign o_score_left       = r_score_l;
    assign o_score_right      = r_score_r;

endmodule

// File: tb/tb_pong_collision_detector.sv
// Scoreboard bench: stimulus pushes expected bounce/miss events, a monitor pops and checks them.
module tb_pong_collision_detector;

    logic       tick = 1'b0;
    logic       reset;
    logic [9:0] row, col;
    logic [2:0] ball, pad;
    logic       fe, serve;
    logic       trig, dir, miss;
    logic [3:0] sl, sr;

    pong_collision_detector dut (
        .i_tick             (tick),
        .i_reset            (reset),
        .i_row              (row),
        .i_col              (col),
        .i_ball_rgb         (ball),
        .i_paddle_rgb       (pad),
        .i_frame_end        (fe),
        .i_serve            (serve),
        .o_bounce_trigger   (trig),
        .o_bounce_direction (dir),
        .o_miss             (miss),
        .o_score_left       (sl),
        .o_score_right      (sr)
    );

    always #5 tick = ~tick;

    int cyc = 0;
    always @(posedge tick) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int model_sl = 0;
    int model_sr = 0;

    typedef struct {
        bit is_miss;
        bit dir;
        int start;
        int width;
        int sl;
        int sr;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor state
    bit   m_prev_trig = 1'b0;
    bit   m_have = 1'b0;
    int   m_hi = 0;
    exp_t m_cur;
    exp_t m_mev;

    initial begin : monitor
        forever begin
            @(negedge tick);
            if (trig && !m_prev_trig) begin
                m_hi = 0;
                if (q.size() == 0) begin
                    check("unexpected_trigger", 1, 0);
                    m_have = 1'b0;
                end else begin
                    m_cur  = q.pop_front();
                    m_have = 1'b1;
                    check("trig_kind", int'(m_cur.is_miss), 0);
                    check("trig_start", cyc, m_cur.start);
                end
            end
            if (trig) begin
                m_hi++;
                if (m_have) check("trig_dir", int'(dir), int'(m_cur.dir));
            end
            if (!trig && m_prev_trig && m_have) begin
                check("trig_width", m_hi, m_cur.width);
                m_have = 1'b0;
            end
            if (miss) begin
                if (q.size() == 0) begin
                    check("unexpected_miss", 1, 0);
                end else begin
                    m_mev = q.pop_front();
                    check("miss_kind", int'(m_mev.is_miss), 1);
                    check("miss_start", cyc, m_mev.start);
                    check("score_left", int'(sl), m_mev.sl);
                    check("score_right", int'(sr), m_mev.sr);
                end
            end
            m_prev_trig = trig;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge tick);
    endtask

    task automatic pixel(input int r, input int c, input logic [2:0] b, input logic [2:0] p);
        row  = 10'(r);
        col  = 10'(c);
        ball = b;
        pad  = p;
        @(negedge tick);
        row  = 10'd490;
        col  = 10'd0;
        ball = 3'b000;
        pad  = 3'b000;
    endtask

    task automatic push(input bit m, input bit d, input int w);
        exp_t e;
        e.is_miss = m;
        e.dir     = d;
        e.start   = cyc + 1;
        e.width   = w;
        e.sl      = model_sl;
        e.sr      = model_sr;
        q.push_back(e);
    endtask

    task automatic frame_end();
        row = 10'd490;
        fe  = 1'b1;
        @(negedge tick);
        fe  = 1'b0;
    endtask

    task automatic empty_frames(input int n);
        repeat (n) begin
            frame_end();
            idle(3);
        end
    endtask

    task automatic serve_pulse();
        serve = 1'b1;
        @(negedge tick);
        serve = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        row   = 10'd490;
        col   = 10'd0;
        ball  = 3'b000;
        pad   = 3'b000;
        fe    = 1'b0;
        serve = 1'b0;
        idle(2);
        check("reset_trig", int'(trig), 0);
        check("reset_dir", int'(dir), 0);
        check("reset_miss", int'(miss), 0);
        check("reset_sl", int'(sl), 0);
        check("reset_sr", int'(sr), 0);
        reset = 1'b0;
        idle(3);

        // Top wall
        pixel(0, 300, 3'b111, 3'b000);
        push(1'b0, 1'b0, 10);
        frame_end();
        idle(15);
        empty_frames(2);

        // Paddle and wall in one frame: paddle wins
        pixel(0, 20, 3'b111, 3'b010);
        push(1'b0, 1'b1, 10);
        frame_end();
        idle(15);
        empty_frames(2);

        // Cooldown: wall hits in four frames, bounces after frames 1 and 4
        pixel(479, 100, 3'b111, 3'b000);
        push(1'b0, 1'b0, 10);
        frame_end();
        idle(15);
        pixel(479, 100, 3'b111, 3'b000);
        frame_end();
        idle(3);
        pixel(479, 100, 3'b111, 3'b000);
        frame_end();
        idle(3);
        pixel(479, 100, 3'b111, 3'b000);
        push(1'b0, 1'b0, 10);
        frame_end();
        idle(15);

        // Right misses until left score saturates
        for (int i = 0; i < 12; i++) begin
            pixel(200, 639, 3'b111, 3'b000);
            model_sl = (model_sl < 9) ? model_sl + 1 : 9;
            push(1'b1, 1'b0, 0);
            frame_end();
            idle(3);
        end
        pixel(100, 0, 3'b111, 3'b000);
        model_sr = model_sr + 1;
        push(1'b1, 1'b0, 0);
        frame_end();
        idle(3);
        pixel(100, 0, 3'b111, 3'b000);
        pixel(101, 639, 3'b111, 3'b000);
        model_sr = model_sr + 1;
        push(1'b1, 1'b0, 0);
        frame_end();
        idle(3);

        // Ball outside the active area sets nothing
        pixel(0, 700, 3'b111, 3'b000);
        pixel(485, 639, 3'b111, 3'b000);
        frame_end();
        idle(3);

        // Serve, then a second serve during HOLD is ignored
        push(1'b0, 1'b1, 10);
        serve_pulse();
        idle(3);
        serve_pulse();
        idle(15);

        // Reset during HOLD after 4 trigger cycles
        empty_frames(2);
        push(1'b0, 1'b1, 4);
        serve_pulse();
        idle(3);
        #1 reset = 1'b1;
        #1;
        check("async_reset_trig", int'(trig), 0);
        check("async_reset_sl", int'(sl), 0);
        check("async_reset_sr", int'(sr), 0);
        check("async_reset_miss", int'(miss), 0);
        model_sl = 0;
        model_sr = 0;
        idle(2);
        reset = 1'b0;
        idle(30);

        // Fresh event after reset
        pixel(0, 300, 3'b111, 3'b000);
        push(1'b0, 1'b0, 10);
        frame_end();
        idle(15);
        empty_frames(2);

        // Serve coinciding with a bouncing frame_end is dropped
        pixel(0, 300, 3'b111, 3'b000);
        push(1'b0, 1'b0, 10);
        row   = 10'd490;
        fe    = 1'b1;
        serve = 1'b1;
        @(negedge tick);
        fe    = 1'b0;
        serve = 1'b0;
        idle(20);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
